fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer_pkg.sv | 22 ++
 rtl/fifo_word_packer_ramp_checker.sv | 73 +++++++
 rtl/fifo_word_packer.sv | 133 +++++++++++++
 tb/tb_fifo_word_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_word_packer_pkg
// Purpose : Shared FIFO constants. Holds the packer FSM state encoding and
//           the default byte width, word size and ramp step used by the
//           FIFO word packer and its ramp checker.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fifo_word_packer_pkg;

  localparam int FIFO_W_DEFAULT = 8;  // FIFO byte width
  localparam int N_DEFAULT      = 4;  // bytes per packed word
  localparam int STEP_DEFAULT   = 2;  // ramp increment

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

endpackage : fifo_word_packer_pkg
`default_nettype wire

// File: rtl/fifo_word_packer_ramp_checker.sv
`default_nettype none
// ============================================================================
// Module  : ramp_checker
// Purpose : Tracks an expected ramp byte that advances by STEP on every pop
//           and counts popped bytes that differ from it while enabled.
// Ports   : clk       - clock
//           rst_n     - asynchronous active-low reset
//           pop       - a byte is consumed this cycle
//           data      - byte being consumed
//           chk_en    - enables mismatch counting
//           err_count - saturating mismatch count
//           err_flag  - sticky mismatch flag
// Revision: 1.0 - initial release
// ============================================================================
module ramp_checker
  import fifo_word_packer_pkg::*;
#(
  parameter int W    = FIFO_W_DEFAULT,
  parameter int STEP = STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pop,
  input  logic [W-1:0] data,
  input  logic         chk_en,
  output logic [7:0]   err_count,
  output logic         err_flag
);

  // Ramp increment reduced to W bits, so the expected byte wraps mod 2^W.
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] expected_q, expected_d;
  logic [7:0]   err_count_q, err_count_d;
  logic         err_flag_q, err_flag_d;
  logic         mismatch;

  assign mismatch = pop & chk_en & (data != expected_q);

  always_comb begin
    expected_d  = expected_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    // The ramp advances on every pop, even with checking disabled, so
    // enabling the check mid-stream stays aligned with the source.
    if (pop) begin
      expected_d = expected_q + STEP_W;
    end
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q  <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;

endmodule : ramp_checker
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_word_packer
// Purpose : Pops bytes from a first-word-fall-through FIFO, packs N of them
//           into one word (byte 0 in the low lane) and offers the word on a
//           valid/ready interface. A ramp checker watches the popped stream.
// Ports   : read_clk   - clock (FIFO read domain)
//           reset      - asynchronous active-low reset
//           fifo_data  - FIFO head byte, valid while fifo_empty=0
//           fifo_empty - FIFO empty flag
//           fifo_rd_en - pop strobe (combinational)
//           word_data  - assembled word
//           word_valid - word_data holds a complete word
//           word_ready - downstream accepts word_data
//           chk_en     - enables ramp checking
//           err_count  - saturating ramp mismatch count
//           err_flag   - sticky ramp mismatch flag
// Revision: 1.0 - initial release
// ============================================================================
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int W    = FIFO_W_DEFAULT,
  parameter int N    = N_DEFAULT,
  parameter int STEP = STEP_DEFAULT
) (
  input  logic           read_clk,
  input  logic           reset,
  input  logic [W-1:0]   fifo_data,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  output logic [W*N-1:0] word_data,
  output logic           word_valid,
  input  logic           word_ready,
  input  logic           chk_en,
  output logic [7:0]     err_count,
  output logic           err_flag
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  pack_state_e    state_q;
  logic [IW-1:0]  idx_q;
  logic [W*N-1:0] word_q;
  logic           valid_q;
  logic           pop;

  // Pop decision is combinational so a full-rate FIFO is drained without a
  // bubble. In HOLD a byte may only be taken when the held word leaves in the
  // same cycle, since lane 0 is overwritten. Reset forces the strobe low.
  always_comb begin
    pop = 1'b0;
    if (reset) begin
      if (state_q == ST_FILL) begin
        pop = ~fifo_empty;
      end else begin
        pop = word_ready & ~fifo_empty;
      end
    end
  end

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (pop) begin
            word_q[idx_q*W +: W] <= fifo_data;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_HOLD;
              valid_q <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        ST_HOLD: begin
          // valid_q is always set here, so word_ready alone completes the
          // handshake.
          if (word_ready) begin
            if (pop) begin
              // Back-to-back: the popped byte starts the next word.
              word_q[W-1:0] <= fifo_data;
              if (N == 1) begin
                state_q <= ST_HOLD;
                valid_q <= 1'b1;
                idx_q   <= '0;
              end else begin
                state_q <= ST_FILL;
                valid_q <= 1'b0;
                idx_q   <= IW'(1);
              end
            end else begin
              state_q <= ST_FILL;
              valid_q <= 1'b0;
              idx_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_FILL;
          valid_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign fifo_rd_en = pop;
  assign word_data  = word_q;
  assign word_valid = valid_q;

  ramp_checker #(
    .W    (W),
    .STEP (STEP)
  ) u_ramp_checker (
    .clk       (read_clk),
    .rst_n     (reset),
    .pop       (pop),
    .data      (fifo_data),
    .chk_en    (chk_en),
    .err_count (err_count),
    .err_flag  (err_flag)
  );

endmodule : fifo_word_packer
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_word_packer
// Purpose : Self-checking bench for fifo_word_packer. A queue models the
//           FWFT FIFO; expected words go into a scoreboard that a monitor
//           drains on every observed word handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int STEP = 2;

  logic           read_clk   = 1'b0;
  logic           reset      = 1'b0;
  logic [W-1:0]   fifo_data  = '0;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic [W*N-1:0] word_data;
  logic           word_valid;
  logic           word_ready = 1'b1;
  logic           chk_en     = 1'b1;
  logic [7:0]     err_count;
  logic           err_flag;

  fifo_word_packer #(
    .W    (W),
    .N    (N),
    .STEP (STEP)
  ) dut (
    .read_clk   (read_clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .chk_en     (chk_en),
    .err_count  (err_count),
    .err_flag   (err_flag)
  );

  always #5 read_clk = ~read_clk;

  logic [W-1:0]   fq[$];     // FIFO contents, head at index 0
  logic [W*N-1:0] exp_q[$];  // scoreboard of expected words
  logic           gate = 1'b0;
  logic           rd_seen = 1'b0;
  int             n_vec = 0;
  int             n_err = 0;
  int             rd_empty_viol = 0;

  function automatic void upd();
    fifo_empty = (fq.size() == 0) || gate;
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: pop decision taken at negedge, applied after the edge.
  always begin
    @(negedge read_clk);
    rd_seen = fifo_rd_en;
    if (fifo_rd_en && fifo_empty) rd_empty_viol++;
    @(posedge read_clk);
    #1;
    if (rd_seen && fq.size() != 0) void'(fq.pop_front());
    upd();
  end

  // Monitor: every accepted word is compared with the scoreboard head.
  always begin
    @(negedge read_clk);
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", word_data);
      end else begin
        chk("word", 64'(word_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge read_clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] b);
    fq.push_back(b);
    upd();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    fq.delete();
    gate = 1'b0;
    upd();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    chk(name, 64'(i >= budget), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    int  pops;
    bit  seen;

    // ---- Reset state, then a straight ramp stream with latency check ----
    for (int b = 0; b < 8; b++) push(8'(b * 2));
    repeat (2) tick();
    @(negedge read_clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_data", 64'(word_data), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_err_flag", 64'(err_flag), 64'd0);
    exp_q.push_back(32'h06040200);
    exp_q.push_back(32'h0E0C0A08);
    tick();
    reset = 1'b1;
    t0 = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge read_clk);
      if (fifo_rd_en) begin
        t0 = $time;
        seen = 1'b1;
      end
    end
    t1 = t0;
    for (int i = 0; i < 20; i++) begin
      if (word_valid) begin
        t1 = $time;
        break;
      end
      @(negedge read_clk);
    end
    chk("latency", 64'((t1 - t0) / 10), 64'(N));
    wait_drain(100, "drain_stream");
    chk("stream_err_count", 64'(err_count), 64'd0);
    chk("stream_err_flag", 64'(err_flag), 64'd0);

    // ---- Back-pressure: word held stable, no pops while stalled ----
    word_ready = 1'b0;
    do_reset();
    for (int b = 0; b < 8; b++) push(8'(b * 2));
    exp_q.push_back(32'h06040200);
    exp_q.push_back(32'h0E0C0A08);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge read_clk);
      seen = word_valid;
    end
    chk("stall_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge read_clk);
      chk("stall_data", 64'(word_data), 64'h06040200);
      chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    tick();
    word_ready = 1'b1;
    wait_drain(100, "drain_stall");

    // ---- fifo_empty toggling every cycle during a fill ----
    do_reset();
    for (int b = 0; b < 4; b++) push(8'(b * 2));
    exp_q.push_back(32'h06040200);
    gate = 1'b1;
    upd();
    pops = 0;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge read_clk);
      if (fifo_rd_en) begin
        if (pops == 0) t0 = $time;
        pops++;
      end
      if (word_valid) begin
        t1 = $time;
        break;
      end
      @(posedge read_clk);
      #2;
      gate = ~gate;
      upd();
    end
    gate = 1'b0;
    upd();
    chk("toggle_pops", 64'(pops), 64'(N));
    chk("toggle_span", 64'((t1 - t0) / 10), 64'(2 * N - 1));
    wait_drain(100, "drain_toggle");

    // ---- Injected mismatch with checking enabled ----
    chk_en = 1'b1;
    do_reset();
    push(8'h00); push(8'h02); push(8'h05); push(8'h06);
    exp_q.push_back(32'h06050200);
    push(8'h08); push(8'h0A); push(8'h0C); push(8'h0E);
    exp_q.push_back(32'h0E0C0A08);
    wait_drain(100, "drain_inject_on");
    chk("inject_on_err_count", 64'(err_count), 64'd1);
    chk("inject_on_err_flag", 64'(err_flag), 64'd1);

    // ---- Same mismatch with checking disabled ----
    chk_en = 1'b0;
    do_reset();
    push(8'h00); push(8'h02); push(8'h05); push(8'h06);
    exp_q.push_back(32'h06050200);
    wait_drain(100, "drain_inject_off");
    chk("inject_off_err_count", 64'(err_count), 64'd0);
    chk("inject_off_err_flag", 64'(err_flag), 64'd0);

    // ---- Reset mid-word discards partial word, ramp restarts ----
    chk_en = 1'b1;
    do_reset();
    push(8'h00); push(8'h02);
    wait_drain(50, "drain_partial");
    tick();
    reset = 1'b0;
    push(8'hAA);
    @(negedge read_clk);
    chk("midrst_valid", 64'(word_valid), 64'd0);
    chk("midrst_data", 64'(word_data), 64'd0);
    chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    tick();
    fq.delete();
    upd();
    reset = 1'b1;
    for (int b = 0; b < 4; b++) push(8'(b * 2));
    exp_q.push_back(32'h06040200);
    wait_drain(100, "drain_after_rst");
    chk("after_rst_err_count", 64'(err_count), 64'd0);
    chk("after_rst_err_flag", 64'(err_flag), 64'd0);

    // ---- 300 mismatching pops saturate the error counter ----
    do_reset();
    for (int b = 0; b < 300; b++) push(8'h01);
    for (int k = 0; k < 75; k++) exp_q.push_back(32'h01010101);
    wait_drain(2000, "drain_saturate");
    chk("sat_err_count", 64'(err_count), 64'd255);
    chk("sat_err_flag", 64'(err_flag), 64'd1);

    chk("rd_en_while_empty", 64'(rd_empty_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_word_packer
`default_nettype wire
